foo_arbiter: RTL
================

# foo_arbiter

Round-robin arbiter and sequencer that shares one `foo` black-box instance among `NUM_REQ` requesters. It accepts one request at a time, drives the operand onto `foo`'s `a` input, and waits a fixed `FOO_LAT` cycles for `foo`'s `x` to settle. It then samples `x` and returns it to the winning requester, tagged with that requester's index. The block sits between the requester-side logic and the `foo` wrapper and owns `foo`'s `a` input exclusively.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..16.
- `FOO_LAT`, 2: cycles from a new `foo_a` value to a valid `foo_x`, 1..15.
- `IDW`, `$clog2(NUM_REQ)`: width of the response id (derived).

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester request valid.
- `req_a`  in  NUM_REQ*32  per-requester operand; slice i is `[32*i+31:32*i]`.
- `req_ready`  out  NUM_REQ  one-hot or zero; high only for the granted requester.
- `rsp_valid`  out  1  response valid.
- `rsp_id`  out  IDW  index of the requester that owns the response.
- `rsp_x`  out  32  sampled `foo_x`.
- `rsp_ready`  in  1  response consumer ready.
- `foo_a`  out  32  registered operand to `foo`.
- `foo_x`  in  32  result from `foo`.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - Grant the first requester with `req_valid` set, searching from `ptr` upward and wrapping modulo `NUM_REQ`.
  - `req_ready[g]` is driven combinationally for the winner only; all other bits are 0.
  - The grant is recomputed every IDLE cycle and is not sticky. A requester that drops `req_valid` before acceptance simply loses the grant.
  - Accept occurs when `req_valid[g]` and `req_ready[g]` are both high at an edge. On accept: `foo_a` <= `req_a[g]`, `id_q` <= g, `ptr` <= (g+1) mod `NUM_REQ`, `cnt` <= `FOO_LAT`, go to WAIT.
  - No `req_valid` set: stay in IDLE; `foo_a` holds its last value.
- WAIT:
  - `cnt` decrements each edge.
  - At the edge where `cnt`==1: `rsp_x` <= `foo_x`, go to RESP.
- RESP:
  - `rsp_valid`=1; `rsp_id`=`id_q`; `rsp_x` is held stable.
  - On `rsp_valid` && `rsp_ready`: go to IDLE.
  - `req_ready` is all-zero in WAIT and RESP.
- `foo_a` holds its value through WAIT and RESP and changes only on accept. This keeps `foo`'s combinational evaluation stable.
- At most one request is ever in flight; there is no queuing.
- `ptr` is IDW bits wide; the wrap from `NUM_REQ`-1 to 0 must be correct for non-power-of-two `NUM_REQ`.

## Timing
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_x`=0, `foo_a`=0, `busy`=0, `ptr`=0, state IDLE.
- Accept at edge E0. `foo_a` is new after E0. `foo_x` is sampled at edge E0+`FOO_LAT`. `rsp_valid` rises after that edge.
- Accept-to-response latency is `FOO_LAT` cycles.
- Minimum request period is `FOO_LAT`+2 cycles with `rsp_ready` tied high: WAIT, one RESP cycle, one IDLE cycle.
- `rsp_ready` low: RESP holds indefinitely with all outputs stable.
- `req_valid` arriving during WAIT or RESP is ignored until IDLE. Requesters must hold `req_valid` and `req_a` until they see `req_ready`.
- `rst` asserted mid-operation (WAIT or RESP):
  - All outputs take their reset values immediately (asynchronous).
  - The in-flight request is dropped with no response.
  - `ptr` returns to 0.
- Deasserting `rst` takes effect at the next edge; the first grant is possible in that same cycle.

## Test plan
- Single request: `req_valid`=4'b0100, `req_a[2]`=32'h0000_1234, `FOO_LAT`=2 model (`foo_x` = `foo_a`+1, two-cycle delay), `rsp_ready`=1. Required: `req_ready`=4'b0100 for one cycle; `rsp_valid` 2 cycles after accept with `rsp_id`=2, `rsp_x`=32'h0000_1235.
- Round-robin fairness: all four `req_valid` held high continuously. Required: grant order 0,1,2,3,0,1; each grant `FOO_LAT`+2 cycles apart.
- Back-pressure: hold `rsp_ready`=0 for 10 cycles during RESP. Required: `rsp_valid`, `rsp_id`, `rsp_x` and `foo_a` stable for all 10 cycles; `req_ready`=0 throughout; completes on the first cycle `rsp_ready`=1.
- Wrap with `NUM_REQ`=3: requests from 2 then 0 pending. Required: after granting 2, `ptr`=0 and 0 is granted next; no phantom index 3 is ever produced.
- Reset mid-WAIT: assert `rst` one cycle after accept. Required: all outputs 0 immediately; no `rsp_valid` afterwards; the first grant after release goes to requester 0 if valid.
- Late arrival: `req_valid[1]` rises during WAIT of requester 0. Required: `req_ready[1]` stays 0 until IDLE, then requester 1 is accepted.

Source files
------------

// File: rtl/foo_arbiter.sv
// Round-robin arbiter/sequencer sharing one fixed-latency foo instance among NUM_REQ requesters.
// One request in flight at a time: grant, drive foo_a, wait FOO_LAT cycles, return the sampled foo_x.
module foo_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned FOO_LAT = 2,
   parameter int unsigned IDW     = $clog2(NUM_REQ)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [NUM_REQ*32-1:0] req_a,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic                 rsp_valid,
   output logic [IDW-1:0]       rsp_id,
   output logic [31:0]          rsp_x,
   input  logic                 rsp_ready,
   output logic [31:0]          foo_a,
   input  logic [31:0]          foo_x,
   output logic                 busy
);

   localparam int unsigned DW = 32;
   localparam int unsigned CW = 4;
   localparam int unsigned SW = IDW + 1;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t         state, state_nxt;
   logic [IDW-1:0] ptr, ptr_nxt, id_q, gnt_idx;
   logic           gnt_found;
   logic [SW-1:0]  sum;
   logic [CW-1:0]  cnt;
   logic           accept, sample;

   // Rotating-priority search starting at ptr; sum never exceeds 2*NUM_REQ-2 so one subtract wraps it
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      sum       = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         sum = SW'(ptr) + SW'(k);
         if (sum >= SW'(NUM_REQ)) sum = sum - SW'(NUM_REQ);
         if (!gnt_found && req_valid[IDW'(sum)]) begin
            gnt_found = 1'b1;
            gnt_idx   = IDW'(sum);
         end
      end
   end

   assign ptr_nxt = (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + IDW'(1);

   // Next state, grant and datapath enables
   always_comb begin
      state_nxt = state;
      req_ready = '0;
      accept    = 1'b0;
      sample    = 1'b0;
      case (state)
         IDLE: begin
            if (gnt_found && !rst) begin
               req_ready[gnt_idx] = 1'b1;
               accept             = 1'b1;
               state_nxt          = WAIT;
            end
         end
         WAIT: begin
            if (cnt == CW'(1)) begin
               sample    = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         ptr   <= '0;
         id_q  <= '0;
         cnt   <= '0;
         foo_a <= '0;
         rsp_x <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            foo_a <= req_a[gnt_idx*DW +: DW];
            id_q  <= gnt_idx;
            ptr   <= ptr_nxt;
            cnt   <= CW'(FOO_LAT);
         end else if (state == WAIT) begin
            cnt <= cnt - CW'(1);
         end
         if (sample) rsp_x <= foo_x;
      end
   end

   assign rsp_valid = (state == RESP);
   assign busy      = (state != IDLE);
   assign rsp_id    = id_q;

endmodule
